// File: rtl/stm_focus_collect.sv
// Double-buffered focus-sample collector: upstream fills the shadow bank, UPDATE publishes it.
// Optional macro STM_FOCUS_COLLECT_FRAME_CNT_EN adds a published-frame counter on FRAME_CNT.
module stm_focus_collect #(
  parameter int DEPTH = 249
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        DIN_VALID,
  input  logic [7:0]  INTENSITY_IN,
  input  logic [7:0]  PHASE_IN,
  input  logic        UPDATE,
  input  logic [7:0]  RD_ADDR,
  output logic [7:0]  INTENSITY_OUT,
  output logic [7:0]  PHASE_OUT,
  output logic        PENDING,
  output logic        SWAPPED,
  output logic        OVERRUN,
  output logic [15:0] FRAME_CNT
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [15:0]   bank_mem [2][DEPTH];
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic          active_q, active_d;
  logic          pending_q, pending_d;
  logic          swapped_q, swapped_d;
  logic          overrun_q, overrun_d;
  logic          published_q, published_d;
  logic [7:0]    int_q, int_d, ph_q, ph_d;

  logic          wr_en, frame_done, swap, in_range;
  logic [AW-1:0] rd_idx;
  logic [15:0]   rd_word;

  // START wins over a coincident sample so the new frame begins cleanly at index 0.
  assign wr_en      = DIN_VALID & ~START;
  assign frame_done = wr_en & (wr_idx_q == LAST);
  assign swap       = UPDATE & (pending_q | frame_done);
  assign rd_idx     = RD_ADDR[AW-1:0];
  assign in_range   = {1'b0, RD_ADDR} < 9'(DEPTH);
  assign rd_word    = bank_mem[active_q][rd_idx];

  always_comb begin
    wr_idx_d    = wr_idx_q;
    active_d    = active_q ^ swap;
    published_d = published_q | swap;
    swapped_d   = swap;
    overrun_d   = frame_done & pending_q & ~UPDATE;
    pending_d   = pending_q;
    int_d       = 8'd0;
    ph_d        = 8'd0;
    if (START)
      wr_idx_d = '0;
    else if (wr_en)
      wr_idx_d = frame_done ? '0 : wr_idx_q + AW'(1);
    if (swap)
      pending_d = 1'b0;
    else if (frame_done)
      pending_d = 1'b1;
    // Bank contents are never reset; the published flag hides them until the first swap.
    if (published_q && in_range) begin
      int_d = rd_word[15:8];
      ph_d  = rd_word[7:0];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_idx_q    <= '0;
      active_q    <= 1'b0;
      pending_q   <= 1'b0;
      swapped_q   <= 1'b0;
      overrun_q   <= 1'b0;
      published_q <= 1'b0;
      int_q       <= 8'd0;
      ph_q        <= 8'd0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      swapped_q   <= swapped_d;
      overrun_q   <= overrun_d;
      published_q <= published_d;
      int_q       <= int_d;
      ph_q        <= ph_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en)
      bank_mem[~active_q][wr_idx_q] <= {INTENSITY_IN, PHASE_IN};
  end

`ifdef STM_FOCUS_COLLECT_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (swap)
      frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) frame_cnt_q <= 16'd0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign FRAME_CNT = frame_cnt_q;
`else
  assign FRAME_CNT = 16'd0;
`endif

  assign INTENSITY_OUT = int_q;
  assign PHASE_OUT     = ph_q;
  assign PENDING       = pending_q;
  assign SWAPPED       = swapped_q;
  assign OVERRUN       = overrun_q;
endmodule

// File: tb/tb_stm_focus_collect.sv
// Directed bench for stm_focus_collect: collect, publish, overrun, restart and reset cases.
module tb_stm_focus_collect;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        DIN_VALID = 1'b0;
  logic [7:0]  INTENSITY_IN = 8'd0;
  logic [7:0]  PHASE_IN = 8'd0;
  logic        UPDATE = 1'b0;
  logic [7:0]  RD_ADDR = 8'd0;
  logic [7:0]  INTENSITY_OUT, PHASE_OUT;
  logic        PENDING, SWAPPED, OVERRUN;
  logic [15:0] FRAME_CNT;

  int total = 0;
  int bad = 0;

  stm_focus_collect #(.DEPTH(249)) dut (
    .CLK(CLK), .RST(RST), .START(START), .DIN_VALID(DIN_VALID),
    .INTENSITY_IN(INTENSITY_IN), .PHASE_IN(PHASE_IN), .UPDATE(UPDATE),
    .RD_ADDR(RD_ADDR), .INTENSITY_OUT(INTENSITY_OUT), .PHASE_OUT(PHASE_OUT),
    .PENDING(PENDING), .SWAPPED(SWAPPED), .OVERRUN(OVERRUN), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Sample i carries intensity=(base+i)%256, phase=255-intensity.
  task automatic send(input int n, input int base, input bit upd_last);
    for (int i = 0; i < n; i++) begin
      DIN_VALID    = 1'b1;
      INTENSITY_IN = 8'((base + i) & 255);
      PHASE_IN     = 8'(255 - ((base + i) & 255));
      UPDATE       = upd_last && (i == n - 1);
      tick();
    end
    DIN_VALID = 1'b0;
    UPDATE    = 1'b0;
  endtask

  task automatic read(input int addr);
    RD_ADDR = 8'(addr);
    tick();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick();
    total++;
    if ({INTENSITY_OUT, PHASE_OUT, PENDING, SWAPPED, OVERRUN, FRAME_CNT} !== 43'd0) begin
      bad++;
      $display("FAIL reset_outputs got i=%0d p=%0d pend=%0b sw=%0b ov=%0b cnt=%0d want all 0",
               INTENSITY_OUT, PHASE_OUT, PENDING, SWAPPED, OVERRUN, FRAME_CNT);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    send(249, 0, 1'b0);
    total++;
    if (PENDING !== 1'b1 || OVERRUN !== 1'b0) begin
      bad++; $display("FAIL basic_pending got pend=%0b ov=%0b want 1/0", PENDING, OVERRUN);
    end
    read(10);
    total++;
    if (INTENSITY_OUT !== 8'd0 || PHASE_OUT !== 8'd0) begin
      bad++; $display("FAIL read_unpublished got %0d/%0d want 0/0", INTENSITY_OUT, PHASE_OUT);
    end
    UPDATE = 1'b1;
    tick();
    UPDATE = 1'b0;
    total++;
    if (SWAPPED !== 1'b1 || PENDING !== 1'b0) begin
      bad++; $display("FAIL basic_swap got sw=%0b pend=%0b want 1/0", SWAPPED, PENDING);
    end
    read(10);
    total++;
    if (SWAPPED !== 1'b0) begin
      bad++; $display("FAIL swap_one_cycle got sw=%0b want 0", SWAPPED);
    end
    total++;
    if (INTENSITY_OUT !== 8'd10 || PHASE_OUT !== 8'd245) begin
      bad++; $display("FAIL read_addr10 got %0d/%0d want 10/245", INTENSITY_OUT, PHASE_OUT);
    end
    read(0);
    total++;
    if (INTENSITY_OUT !== 8'd0 || PHASE_OUT !== 8'd255) begin
      bad++; $display("FAIL read_addr0 got %0d/%0d want 0/255", INTENSITY_OUT, PHASE_OUT);
    end
    read(248);
    total++;
    if (INTENSITY_OUT !== 8'd248 || PHASE_OUT !== 8'd7) begin
      bad++; $display("FAIL read_addr248 got %0d/%0d want 248/7", INTENSITY_OUT, PHASE_OUT);
    end
    read(249);
    total++;
    if (INTENSITY_OUT !== 8'd0 || PHASE_OUT !== 8'd0) begin
      bad++; $display("FAIL read_addr249 got %0d/%0d want 0/0", INTENSITY_OUT, PHASE_OUT);
    end
    // UPDATE with nothing pending must leave the active bank alone.
    RD_ADDR = 8'd10;
    UPDATE  = 1'b1;
    tick();
    UPDATE  = 1'b0;
    total++;
    if (SWAPPED !== 1'b0) begin
      bad++; $display("FAIL idle_update got sw=%0b want 0", SWAPPED);
    end
    read(10);
    total++;
    if (INTENSITY_OUT !== 8'd10 || PHASE_OUT !== 8'd245) begin
      bad++; $display("FAIL idle_update_read got %0d/%0d want 10/245", INTENSITY_OUT, PHASE_OUT);
    end
  endtask

  task automatic test_overrun();
    send(249, 100, 1'b0);
    total++;
    if (OVERRUN !== 1'b0 || PENDING !== 1'b1) begin
      bad++; $display("FAIL overrun_first got ov=%0b pend=%0b want 0/1", OVERRUN, PENDING);
    end
    send(249, 50, 1'b0);
    total++;
    if (OVERRUN !== 1'b1 || PENDING !== 1'b1) begin
      bad++; $display("FAIL overrun_second got ov=%0b pend=%0b want 1/1", OVERRUN, PENDING);
    end
    tick();
    total++;
    if (OVERRUN !== 1'b0) begin
      bad++; $display("FAIL overrun_one_cycle got ov=%0b want 0", OVERRUN);
    end
    UPDATE = 1'b1;
    tick();
    UPDATE = 1'b0;
    total++;
    if (SWAPPED !== 1'b1) begin
      bad++; $display("FAIL overrun_swap got sw=%0b want 1", SWAPPED);
    end
    read(10);
    total++;
    if (INTENSITY_OUT !== 8'd60 || PHASE_OUT !== 8'd195) begin
      bad++; $display("FAIL overrun_newer_data got %0d/%0d want 60/195", INTENSITY_OUT, PHASE_OUT);
    end
  endtask

  task automatic test_start_restart();
    send(100, 200, 1'b0);
    START        = 1'b1;
    DIN_VALID    = 1'b1;
    INTENSITY_IN = 8'hAA;
    PHASE_IN     = 8'hAA;
    tick();
    START        = 1'b0;
    DIN_VALID    = 1'b0;
    send(249, 30, 1'b1);
    total++;
    if (SWAPPED !== 1'b1 || OVERRUN !== 1'b0 || PENDING !== 1'b0) begin
      bad++; $display("FAIL start_update_last got sw=%0b ov=%0b pend=%0b want 1/0/0",
                      SWAPPED, OVERRUN, PENDING);
    end
    read(0);
    total++;
    if (INTENSITY_OUT !== 8'd30 || PHASE_OUT !== 8'd225) begin
      bad++; $display("FAIL start_addr0 got %0d/%0d want 30/225", INTENSITY_OUT, PHASE_OUT);
    end
    read(248);
    total++;
    if (INTENSITY_OUT !== 8'd22 || PHASE_OUT !== 8'd233) begin
      bad++; $display("FAIL start_addr248 got %0d/%0d want 22/233", INTENSITY_OUT, PHASE_OUT);
    end
  endtask

  task automatic test_reset_mid_frame();
    read(10);
    send(50, 5, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    total++;
    if ({INTENSITY_OUT, PHASE_OUT, PENDING, SWAPPED, OVERRUN, FRAME_CNT} !== 43'd0) begin
      bad++; $display("FAIL reset_mid_outputs got i=%0d p=%0d pend=%0b cnt=%0d want 0",
                      INTENSITY_OUT, PHASE_OUT, PENDING, FRAME_CNT);
    end
    tick();
    RST = 1'b0;
    tick();
    read(10);
    total++;
    if (INTENSITY_OUT !== 8'd0 || PHASE_OUT !== 8'd0) begin
      bad++; $display("FAIL reset_mid_unpublished got %0d/%0d want 0/0", INTENSITY_OUT, PHASE_OUT);
    end
    send(249, 9, 1'b1);
    total++;
    if (SWAPPED !== 1'b1 || PENDING !== 1'b0) begin
      bad++; $display("FAIL reset_mid_swap got sw=%0b pend=%0b want 1/0", SWAPPED, PENDING);
    end
    read(10);
    total++;
    if (INTENSITY_OUT !== 8'd19 || PHASE_OUT !== 8'd236) begin
      bad++; $display("FAIL reset_mid_read got %0d/%0d want 19/236", INTENSITY_OUT, PHASE_OUT);
    end
  endtask

  task automatic test_frame_cnt();
    logic [15:0] exp_cnt;
`ifdef STM_FOCUS_COLLECT_FRAME_CNT_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    for (int f = 0; f < 3; f++) begin
      send(249, f, 1'b1);
      tick();
    end
    total++;
    if (FRAME_CNT !== exp_cnt) begin
      bad++; $display("FAIL frame_cnt got %0d want %0d", FRAME_CNT, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_start_restart();
    test_reset_mid_frame();
    test_frame_cnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
